// File: rtl/ctx_regfile_pkg.sv
// Shared types and sizing helpers for the context-stacked register file.
package ctx_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Encoded as {push, pop} so the raw inputs cast straight onto it.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_POP  = 2'b01,
    CMD_PUSH = 2'b10,
    CMD_SWAP = 2'b11
  } cmd_e;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int slot_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ctx_stack_ctrl.sv
// Stack pointer for the snapshot banks: accepts or rejects push/pop/swap
// against full/empty and produces the slot index plus error pulses.
module ctx_stack_ctrl
  import ctx_regfile_pkg::*;
#(
  parameter  int CTX_DEPTH = 3,
  localparam int LVL_W     = lvl_w(CTX_DEPTH),
  localparam int SLOT_W    = slot_w(CTX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [LVL_W-1:0]  ctx_level,
  output logic              full,
  output logic              empty,
  output logic              do_push,
  output logic              do_pop,
  output logic              do_swap,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              ovf_err,
  output logic              unf_err
);

  logic [LVL_W-1:0] level_q, level_d, slot_full;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  cmd_e             cmd;

  assign cmd   = cmd_e'({push, pop});
  assign full  = (level_q == LVL_W'(CTX_DEPTH));
  assign empty = (level_q == '0);

  always_comb begin
    level_d   = level_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_swap   = 1'b0;
    // push targets the first free slot; pop/swap operate on the top
    slot_full = (cmd == CMD_PUSH) ? level_q : level_q - LVL_W'(1);
    if (!rst) begin
      case (cmd)
        CMD_NONE: ;
        CMD_PUSH:
          if (full) ovf_d = 1'b1;
          else begin
            do_push = 1'b1;
            level_d = level_q + LVL_W'(1);
          end
        CMD_POP:
          if (empty) unf_d = 1'b1;
          else begin
            do_pop  = 1'b1;
            level_d = level_q - LVL_W'(1);
          end
        CMD_SWAP:
          if (empty) unf_d = 1'b1;
          else do_swap = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign slot_idx  = slot_full[SLOT_W-1:0];
  assign ctx_level = level_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule

// File: rtl/ctx_regfile.sv
// Live register file with a LIFO of full-file snapshots for nested
// interrupt entry/exit; two combinational read ports, one write port.
module ctx_regfile
  import ctx_regfile_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int CTX_DEPTH = 3,
  parameter  bit ZERO_REG  = 1'b1,
  parameter  bit BYPASS    = 1'b0,
  localparam int LVL_W     = lvl_w(CTX_DEPTH),
  localparam int SLOT_W    = slot_w(CTX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r1_num,
  input  logic [ADDR_W-1:0] r2_num,
  output logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] r2_data,
  input  logic [ADDR_W-1:0] w_num,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              push,
  input  logic              pop,
  output logic [LVL_W-1:0]  ctx_level,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int NREG = 2 ** ADDR_W;

  typedef logic [NREG-1:0][DATA_W-1:0] bank_t;

  bank_t                       live_q, live_d, wr_next;
  bank_t [CTX_DEPTH-1:0]       snap_q, snap_d;
  logic                        do_push, do_pop, do_swap;
  logic [SLOT_W-1:0]           slot_idx;
  logic                        wr_ok;

  ctx_stack_ctrl #(.CTX_DEPTH(CTX_DEPTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .ctx_level (ctx_level),
    .full      (full),
    .empty     (empty),
    .do_push   (do_push),
    .do_pop    (do_pop),
    .do_swap   (do_swap),
    .slot_idx  (slot_idx),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  assign wr_ok = we && !(ZERO_REG && (w_num == '0));

  always_comb begin
    wr_next = live_q;
    if (wr_ok) wr_next[w_num] = din;
    live_d = wr_next;
    snap_d = snap_q;
    if (do_push) snap_d[slot_idx] = wr_next;
    // a restore discards the same-cycle write from live; swap parks it in the slot
    if (do_pop || do_swap) live_d = snap_q[slot_idx];
    if (do_swap) snap_d[slot_idx] = wr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) live_q <= '0;
    else     live_q <= live_d;
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] num);
    logic [DATA_W-1:0] v;
    v = live_q[num];
    if (BYPASS && wr_ok && (w_num == num) && !(do_pop || do_swap)) v = din;
    if (ZERO_REG && (num == '0)) v = '0;
    return v;
  endfunction

  assign r1_data = rd_port(r1_num);
  assign r2_data = rd_port(r2_num);

endmodule

// File: tb/tb_ctx_regfile.sv
// Vector-table bench for ctx_regfile plus a bypass/depth-1 instance.
module tb_ctx_regfile;

  logic        clk = 1'b0;
  logic        rst, we, push, pop;
  logic [4:0]  r1_num, r2_num, w_num;
  logic [31:0] din;

  logic [31:0] r1_data, r2_data, bp_r1, bp_r2;
  logic [1:0]  ctx_level;
  logic [0:0]  bp_level;
  logic        full, empty, ovf_err, unf_err;
  logic        bp_full, bp_empty, bp_ovf, bp_unf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ctx_regfile dut (
    .clk(clk), .rst(rst), .r1_num(r1_num), .r2_num(r2_num),
    .r1_data(r1_data), .r2_data(r2_data), .w_num(w_num), .din(din),
    .we(we), .push(push), .pop(pop), .ctx_level(ctx_level), .full(full),
    .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  ctx_regfile #(.CTX_DEPTH(1), .BYPASS(1'b1)) dut_bp (
    .clk(clk), .rst(rst), .r1_num(r1_num), .r2_num(r2_num),
    .r1_data(bp_r1), .r2_data(bp_r2), .w_num(w_num), .din(din),
    .we(we), .push(push), .pop(pop), .ctx_level(bp_level), .full(bp_full),
    .empty(bp_empty), .ovf_err(bp_ovf), .unf_err(bp_unf)
  );

  typedef struct {
    logic        rst, we;
    logic [4:0]  w;
    logic [31:0] din;
    logic        push, pop;
    logic [4:0]  r1, r2;
    logic [31:0] e1, e2;
    logic [1:0]  lvl;
    logic        ovf, unf;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic add(input logic rs, input logic w_e, input logic [4:0] w, input logic [31:0] d,
                     input logic pu, input logic po, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2, input logic [1:0] lvl,
                     input logic ovf, input logic unf);
    vec_t v;
    v.rst = rs; v.we = w_e; v.w = w; v.din = d; v.push = pu; v.pop = po;
    v.r1 = a1; v.r2 = a2; v.e1 = e1; v.e2 = e2; v.lvl = lvl; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rs, input logic w_e, input logic [4:0] w, input logic [31:0] d,
                       input logic pu, input logic po, input logic [4:0] a1, input logic [4:0] a2);
    rst = rs; we = w_e; w_num = w; din = d; push = pu; pop = po; r1_num = a1; r2_num = a2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    // Expected values are what is observed during the vector's own cycle,
    // i.e. the state left by all earlier edges.
    //   rst we w  din            pu po r1 r2  e1             e2             lvl ovf unf
    add(0, 1, 5, 32'hA5A5_0001, 0, 0, 5, 0, 32'h0,          32'h0,          0, 0, 0);
    add(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 5, 0, 32'hA5A5_0001, 32'h0,          0, 0, 0);
    add(0, 1, 3, 32'h11,        0, 0, 0, 5, 32'h0,          32'hA5A5_0001, 0, 0, 0);
    add(0, 1, 3, 32'h22,        1, 0, 3, 0, 32'h11,         32'h0,          0, 0, 0);
    add(0, 1, 3, 32'h33,        0, 0, 3, 0, 32'h22,         32'h0,          1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 3, 0, 32'h33,         32'h0,          1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 3, 0, 32'h22,         32'h0,          0, 0, 0);
    add(0, 1, 1, 32'h1,         0, 0, 1, 0, 32'h0,          32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h1,          32'h0,          0, 0, 0);
    add(0, 1, 1, 32'h2,         0, 0, 1, 0, 32'h1,          32'h0,          1, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h2,          32'h0,          1, 0, 0);
    add(0, 1, 1, 32'h3,         0, 0, 1, 0, 32'h2,          32'h0,          2, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h3,          32'h0,          2, 0, 0);
    add(0, 1, 1, 32'h9,         1, 0, 1, 0, 32'h3,          32'h0,          3, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h9,          32'h0,          3, 1, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h9,          32'h0,          3, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h9,          32'h0,          3, 1, 0);
    add(0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h9,          32'h0,          3, 1, 0);
    add(0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h3,          32'h0,          2, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h2,          32'h0,          1, 0, 0);
    add(0, 1, 4, 32'h44,        0, 1, 1, 4, 32'h1,          32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 4, 3, 32'h44,         32'h22,         0, 0, 1);
    add(0, 1, 2, 32'hAA,        0, 0, 2, 0, 32'h0,          32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 2, 0, 32'hAA,         32'h0,          0, 0, 0);
    add(0, 1, 2, 32'hBB,        0, 0, 2, 0, 32'hAA,         32'h0,          1, 0, 0);
    add(0, 1, 2, 32'hCC,        1, 1, 2, 0, 32'hBB,         32'h0,          1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 2, 0, 32'hAA,         32'h0,          1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 2, 0, 32'hAA,         32'h0,          1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 2, 4, 32'hCC,         32'h44,         0, 0, 0);
    add(0, 1, 6, 32'h66,        1, 1, 6, 0, 32'h0,          32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 6, 0, 32'h66,         32'h0,          0, 0, 1);
    add(0, 0, 0, 32'h0,         1, 0, 6, 0, 32'h66,         32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 0, 32'h1,          32'h0,          1, 0, 0);
    add(1, 1, 1, 32'h5,         1, 0, 1, 0, 32'h1,          32'h0,          2, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 1, 5, 32'h0,          32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 1, 0, 32'h0,          32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0,          32'h0,          0, 0, 1);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].w, tbl[i].din, tbl[i].push, tbl[i].pop, tbl[i].r1, tbl[i].r2);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("r1_data", i, r1_data, e.e1);
      chk("r2_data", i, r2_data, e.e2);
      chk("ctx_level", i, 32'(ctx_level), 32'(e.lvl));
      chk("full", i, 32'(full), 32'(e.lvl == 2'd3));
      chk("empty", i, 32'(empty), 32'(e.lvl == 2'd0));
      chk("ovf_err", i, 32'(ovf_err), 32'(e.ovf));
      chk("unf_err", i, 32'(unf_err), 32'(e.unf));
      @(posedge clk);
      #1;
    end

    // Bypass and depth-1 corner cases on the second instance.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 7, 32'h77, 0, 0, 0, 7);
    @(negedge clk);
    chk("bp_same_cycle", 0, bp_r2, 32'h77);
    chk("nobp_same_cycle", 0, r2_data, 32'h0);
    chk("bp_empty_rst", 0, 32'(bp_empty), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 0, 7);
    @(negedge clk);
    chk("bp_full_pre", 0, 32'(bp_full), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    @(negedge clk);
    chk("d1_level", 0, 32'(bp_level), 32'd1);
    chk("d1_full", 0, 32'(bp_full), 32'd1);
    chk("d1_empty", 0, 32'(bp_empty), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 0, 7);
    @(posedge clk); #1;
    drive(0, 1, 7, 32'h99, 0, 1, 0, 7);
    @(negedge clk);
    chk("d1_ovf", 0, 32'(bp_ovf), 32'd1);
    chk("d1_level_ovf", 0, 32'(bp_level), 32'd1);
    chk("bp_pop_cycle", 0, bp_r2, 32'h77);
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h5, 0, 0, 0, 7);
    @(negedge clk);
    chk("d1_level_pop", 0, 32'(bp_level), 32'd0);
    chk("bp_after_pop", 0, bp_r2, 32'h77);
    chk("bp_zero_reg", 0, bp_r1, 32'h0);
    chk("d1_ovf_done", 0, 32'(bp_ovf), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
